// File: rtl/fwd_sel_if.sv
// Bundle between the D-stage decode and the hazard/forwarding controller.
// With FWD_STATS_EN defined the bundle also carries the stall/forward counters.
interface fwd_sel_if #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
);
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic              d_use_rs;
  logic              d_use_rt;
  logic [REG_AW-1:0] d_a3;
  logic              d_we;
  logic [TNEW_W-1:0] d_tnew;
  logic              flush;
  logic              stall;
  logic [2:0]        sel_rs;
  logic [2:0]        sel_rt;
  logic [REG_AW-1:0] e_a3_q;
`ifdef FWD_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       fwd_cnt;
`endif

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_use_rs, d_use_rt,
           d_a3, d_we, d_tnew, flush,
    input  stall, sel_rs, sel_rt, e_a3_q
`ifdef FWD_STATS_EN
    , stall_cnt, fwd_cnt
`endif
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_use_rs, d_use_rt,
           d_a3, d_we, d_tnew, flush,
    output stall, sel_rs, sel_rt, e_a3_q
`ifdef FWD_STATS_EN
    , stall_cnt, fwd_cnt
`endif
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// Hazard/forwarding controller: tracks E/M/W destinations and Tnew, drives mux selects and D stall.
// Define FWD_STATS_EN to add saturating stall_cnt/fwd_cnt statistics outputs.
module fwd_sel_ctrl #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
) (
  input logic      clk,
  input logic      reset,
  fwd_sel_if.slave bus
);
  localparam logic [2:0] SEL_RF   = 3'd0;
  localparam logic [2:0] SEL_E    = 3'd1;
  localparam logic [2:0] SEL_M    = 3'd2;
  localparam logic [2:0] SEL_W    = 3'd3;
  localparam logic [2:0] SEL_HOLD = 3'd4;
  localparam logic [2:0] SEL_ZERO = 3'd5;

  logic              vld_p0, vld_p1, vld_p2;
  logic [REG_AW-1:0] a3_p0, a3_p1, a3_p2;
  logic [TNEW_W-1:0] tnew_p0, tnew_p1, tnew_p2;
  logic              hold_rs, hold_rt;

  logic [2:0]        hit_rs, hit_rt, rdy;
  logic              stall_rs, stall_rt, stall_c;
  logic [2:0]        sel_rs_c, sel_rt_c;

  function automatic logic hit(input logic vld, input logic [REG_AW-1:0] a3,
                               input logic [REG_AW-1:0] src, input logic use_s);
    return vld && use_s && (a3 != '0) && (a3 == src);
  endfunction

  // Only the youngest matching producer decides; older entries never mask it.
  function automatic logic need_stall(input logic [2:0] h, input logic [TNEW_W-1:0] t0,
                                      input logic [TNEW_W-1:0] t1, input logic [TNEW_W-1:0] t2,
                                      input logic [TNEW_W-1:0] tuse);
    if (h[0]) return t0 > tuse;
    if (h[1]) return t1 > tuse;
    if (h[2]) return t2 > tuse;
    return 1'b0;
  endfunction

  function automatic logic [2:0] pick_sel(input logic zero_src, input logic [2:0] h,
                                          input logic [2:0] r, input logic hold);
    if (zero_src)       return SEL_ZERO;
    if (h[0] && r[0])   return SEL_E;
    if (h[1] && r[1])   return SEL_M;
    if (h[2] && r[2])   return SEL_W;
    if (hold && h == 3'b000) return SEL_HOLD;
    return SEL_RF;
  endfunction

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  always_comb begin
    rdy      = {tnew_p2 == '0, tnew_p1 == '0, tnew_p0 == '0};
    hit_rs   = {hit(vld_p2, a3_p2, bus.d_rs, bus.d_use_rs),
                hit(vld_p1, a3_p1, bus.d_rs, bus.d_use_rs),
                hit(vld_p0, a3_p0, bus.d_rs, bus.d_use_rs)};
    hit_rt   = {hit(vld_p2, a3_p2, bus.d_rt, bus.d_use_rt),
                hit(vld_p1, a3_p1, bus.d_rt, bus.d_use_rt),
                hit(vld_p0, a3_p0, bus.d_rt, bus.d_use_rt)};
    stall_rs = need_stall(hit_rs, tnew_p0, tnew_p1, tnew_p2, bus.d_tuse_rs);
    stall_rt = need_stall(hit_rt, tnew_p0, tnew_p1, tnew_p2, bus.d_tuse_rt);
    stall_c  = stall_rs || stall_rt;
    sel_rs_c = pick_sel(bus.d_use_rs && (bus.d_rs == '0), hit_rs, rdy, hold_rs);
    sel_rt_c = pick_sel(bus.d_use_rt && (bus.d_rt == '0), hit_rt, rdy, hold_rt);
  end

  assign bus.stall  = stall_c;
  assign bus.sel_rs = sel_rs_c;
  assign bus.sel_rt = sel_rt_c;
  assign bus.e_a3_q = a3_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      a3_p0   <= '0;
      a3_p1   <= '0;
      a3_p2   <= '0;
      tnew_p0 <= '0;
      tnew_p1 <= '0;
      tnew_p2 <= '0;
      hold_rs <= 1'b0;
      hold_rt <= 1'b0;
    end else begin
      // M -> W
      vld_p2  <= vld_p1;
      a3_p2   <= a3_p1;
      tnew_p2 <= tnew_p1;
      // E -> M
      vld_p1  <= vld_p0;
      a3_p1   <= a3_p0;
      tnew_p1 <= tnew_dec(tnew_p0);
      // D -> E
      if (stall_c || bus.flush) begin
        vld_p0  <= 1'b0;
        a3_p0   <= '0;
        tnew_p0 <= '0;
      end else begin
        vld_p0  <= bus.d_we && (bus.d_a3 != '0);
        a3_p0   <= bus.d_a3;
        tnew_p0 <= bus.d_tnew;
      end
      // Held operand: armed when W satisfies a stalled source, released once D advances.
      hold_rs <= stall_c && (hold_rs || hit_rs[2]);
      hold_rt <= stall_c && (hold_rt || hit_rt[2]);
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;
  logic [1:0]  fwd_inc;

  function automatic logic is_fwd(input logic [2:0] sel);
    return (sel >= SEL_E) && (sel <= SEL_HOLD);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_comb fwd_inc = {1'b0, is_fwd(sel_rs_c)} + {1'b0, is_fwd(sel_rt_c)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= sat_add(stall_cnt_q, {1'b0, stall_c});
      fwd_cnt_q   <= sat_add(fwd_cnt_q, fwd_inc);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif
endmodule
